cordic_iter: RTL and testbench



---
 rtl/cordic_pkg.sv | 94 +++++++++
 rtl/cordic_iter_if.sv | 24 ++
 rtl/cordic_atan_rom.sv | 22 ++
 rtl/cordic_iter.sv | 151 +++++++++++++++
 tb/tb_cordic_iter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the cordic_iter engine: FSM states, quadrant
// codes and the arctangent / gain-constant generators.
package cordic_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_GAIN = 2'd2,
    S_DONE = 2'd3
  } cordic_state_e;

  // Top two angle bits that trigger a +/- quarter-turn pre-rotation.
  localparam logic [1:0] QUAD_POS_HI = 2'b01;
  localparam logic [1:0] QUAD_NEG_HI = 2'b10;

  // atan(2^-i) with pi scaled to 2^31.
  function automatic logic [31:0] atan_ref(input int i);
    case (i)
      0:  return 32'd536870912;
      1:  return 32'd316933406;
      2:  return 32'd167458907;
      3:  return 32'd85004756;
      4:  return 32'd42667331;
      5:  return 32'd21354465;
      6:  return 32'd10679838;
      7:  return 32'd5340245;
      8:  return 32'd2670163;
      9:  return 32'd1335087;
      10: return 32'd667544;
      11: return 32'd333772;
      12: return 32'd166886;
      13: return 32'd83443;
      14: return 32'd41722;
      15: return 32'd20861;
      16: return 32'd10430;
      17: return 32'd5215;
      18: return 32'd2608;
      19: return 32'd1304;
      20: return 32'd652;
      21: return 32'd326;
      22: return 32'd163;
      23: return 32'd81;
      24: return 32'd41;
      25: return 32'd20;
      26: return 32'd10;
      27: return 32'd5;
      28: return 32'd3;
      29: return 32'd1;
      30: return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  // Product of 1/sqrt(1+2^-2i) for i=0..n-1, scaled to 2^31.
  function automatic logic [31:0] gain_ref(input int n);
    case (n)
      1:  return 32'd1518500250;
      2:  return 32'd1358187913;
      3:  return 32'd1317635818;
      4:  return 32'd1307460870;
      5:  return 32'd1304914692;
      6:  return 32'd1304277993;
      7:  return 32'd1304118809;
      8:  return 32'd1304079012;
      9:  return 32'd1304069063;
      10: return 32'd1304066576;
      11: return 32'd1304065954;
      12: return 32'd1304065798;
      13: return 32'd1304065759;
      14: return 32'd1304065750;
      15: return 32'd1304065747;
      default: return 32'd1304065746;
    endcase
  endfunction

  // Rescale a 2^31-based constant to 2^(iw-1), rounding to nearest.
  function automatic logic [31:0] scale_round(input logic [31:0] v, input int iw);
    int          s;
    logic [32:0] t;
    s = 32 - iw;
    if (s <= 0) return v;
    t = {1'b0, v} + (33'd1 << (s - 1));
    return 32'(t >> s);
  endfunction

  function automatic logic [31:0] cordic_atan(input int iw, input int i);
    return scale_round(atan_ref(i), iw);
  endfunction

  function automatic logic [31:0] cordic_gain(input int iw, input int n);
    return scale_round(gain_ref(n), iw);
  endfunction

endpackage

// File: rtl/cordic_iter_if.sv
// Operand/result bus of cordic_iter. Both sides are valid/ready: a transfer
// happens on the rising edge where valid & ready are 1; valid never waits on ready.
interface cordic_iter_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [W-1:0] z_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic [W-1:0] z_out;

  modport slave (
    input  in_valid, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out
  );

  modport master (
    output in_valid, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_atan_rom.sv
// Constant arctangent table for the CORDIC micro-rotations: atan(2^-i) with
// pi mapped to 2^(IW-1).
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int IW = 18,
  parameter int N  = 14,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [CW-1:0] i_i,
  output logic [IW-1:0] atan_o
);

  logic [IW-1:0] rom [2**CW];

  for (genvar k = 0; k < 2**CW; k++) begin : g_rom
    assign rom[k] = (k < N) ? IW'(cordic_atan(IW, k)) : '0;
  end

  assign atan_o = rom[i_i];

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC rotation engine, one micro-rotation per clock with quadrant
// pre-rotation. Define CORDIC_GAIN_COMP_EN to add a unit-gain scaling step.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int W = 16,
  parameter int G = 2,
  parameter int N = 14
) (
  input  logic          clk,
  input  logic          rst,
  cordic_iter_if.slave  bus,
  output cordic_state_e state_o
);

  localparam int IW = W + G;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] I_LAST = CW'(N - 1);
  localparam logic signed [IW-1:0] QUARTER = {2'b01, {(IW-2){1'b0}}};

  cordic_state_e         state_q;
  logic [CW-1:0]         i_q;
  logic signed [IW-1:0]  x_q, y_q, z_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic [IW-1:0]         atan_w;
  logic signed [IW-1:0]  x_ext, y_ext, z_ext;
  logic signed [IW-1:0]  x_cap_d, y_cap_d, z_cap_d;
  logic signed [IW-1:0]  x_rot_d, y_rot_d, z_rot_d;

  cordic_atan_rom #(.IW(IW), .N(N), .CW(CW)) u_rom (
    .i_i    (i_q),
    .atan_o (atan_w)
  );

  // Capture path: left-align into IW bits and fold the angle into [-pi/2, pi/2).
  always_comb begin
    x_ext   = IW'($signed(bus.x_in)) <<< G;
    y_ext   = IW'($signed(bus.y_in)) <<< G;
    z_ext   = IW'($signed(bus.z_in)) <<< G;
    x_cap_d = x_ext;
    y_cap_d = y_ext;
    z_cap_d = z_ext;
    if (bus.z_in[W-1:W-2] == QUAD_POS_HI) begin
      x_cap_d = -y_ext;
      y_cap_d = x_ext;
      z_cap_d = z_ext - QUARTER;
    end else if (bus.z_in[W-1:W-2] == QUAD_NEG_HI) begin
      x_cap_d = y_ext;
      y_cap_d = -x_ext;
      z_cap_d = z_ext + QUARTER;
    end
  end

  always_comb begin
    if (!z_q[IW-1]) begin
      x_rot_d = x_q - (y_q >>> i_q);
      y_rot_d = y_q + (x_q >>> i_q);
      z_rot_d = z_q - atan_w;
    end else begin
      x_rot_d = x_q + (y_q >>> i_q);
      y_rot_d = y_q - (x_q >>> i_q);
      z_rot_d = z_q + atan_w;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [IW-1:0] K_GAIN = IW'(cordic_gain(IW, N));

  logic signed [2*IW-1:0] x_prod, y_prod;
  logic signed [IW-1:0]   x_gain_d, y_gain_d;

  // K is a Q(IW-1) fraction, so the product is realigned by IW-1 bits.
  always_comb begin
    x_prod   = x_q * K_GAIN;
    y_prod   = y_q * K_GAIN;
    x_gain_d = IW'(x_prod >>> (IW - 1));
    y_gain_d = IW'(y_prod >>> (IW - 1));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_q        <= x_cap_d;
            y_q        <= y_cap_d;
            z_q        <= z_cap_d;
            i_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_ITER;
          end
        end
        S_ITER: begin
          x_q <= x_rot_d;
          y_q <= y_rot_d;
          z_q <= z_rot_d;
          if (i_q == I_LAST) begin
            i_q <= '0;
`ifdef CORDIC_GAIN_COMP_EN
            state_q <= S_GAIN;
`else
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
`endif
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_GAIN: begin
          x_q         <= x_gain_d;
          y_q         <= y_gain_d;
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_q[IW-1:G];
  assign bus.y_out     = y_q[IW-1:G];
  assign bus.z_out     = z_q[IW-1:G];
  assign state_o       = state_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Directed and swept checks of cordic_iter at W=16, G=2, N=14; expectations
// follow the build's CORDIC_GAIN_COMP_EN setting.
module tb_cordic_iter;
  import cordic_pkg::*;

  localparam int W = 16;
  localparam int G = 2;
  localparam int N = 14;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = N + 1;
`else
  localparam int LAT = N;
`endif
  localparam int TOL       = 3;
  localparam int ZTOL      = 3;
  localparam int SWEEP_TOL = 6;
  localparam int MAX_WAIT  = 200;
  localparam real PI       = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  cordic_state_e state;

  cordic_iter_if #(.W(W)) bus ();

  cordic_iter #(.W(W), .G(G), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int last_lat;
  logic signed [W-1:0] rx, ry, rz;
  real ag;

  task automatic check(input string tag, input int obs, input int exp_v, input int tol);
    int d;
    n_checks++;
    d = obs - exp_v;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp_v, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input int x, input int y, input int z);
    int w;
    w = 0;
    bus.x_in     = W'(x);
    bus.y_in     = W'(y);
    bus.z_in     = W'(z);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < MAX_WAIT) begin
      tick();
      w++;
    end
    if (!bus.in_ready) check("accept_timeout", 0, 1, 0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result();
    last_lat = 0;
    while (!bus.out_valid && last_lat < MAX_WAIT) begin
      tick();
      last_lat++;
    end
    if (!bus.out_valid) check("result_timeout", 0, 1, 0);
    rx = bus.x_out;
    ry = bus.y_out;
    rz = bus.z_out;
  endtask

  task automatic score(input string tag, input int tol);
    logic [W-1:0] ex, ey;
    if (exp_q.size() < 2) begin
      check({tag, "_sb_empty"}, exp_q.size(), 2, 0);
      return;
    end
    ex = exp_q.pop_front();
    ey = exp_q.pop_front();
    check({tag, "_x"}, int'(rx), int'($signed(ex)), tol);
    check({tag, "_y"}, int'(ry), int'($signed(ey)), tol);
    check({tag, "_z"}, int'(rz), 0, ZTOL);
  endtask

  task automatic run_op(input string tag, input int x, input int y, input int z,
                        input int ex, input int ey, input int tol);
    exp_q.push_back(W'(ex));
    exp_q.push_back(W'(ey));
    send_op(x, y, z);
    wait_result();
    check({tag, "_lat"}, last_lat, LAT, 0);
    score(tag, tol);
    tick();
    check({tag, "_drop"}, int'(bus.out_valid), 0, 0);
  endtask

  // Directed vectors: x, y, z in, expected x, y out.
  int vec [4][5] = '{
`ifdef CORDIC_GAIN_COMP_EN
    '{10000, 0,      0,  10000,     0},
    '{10000, 0,   8192,   7071,  7071},
    '{10000, 0, -32768, -10000,     0},
    '{10000, 0,  24576,  -7071,  7071}
`else
    '{10000, 0,      0,  16467,     0},
    '{10000, 0,   8192,  11644, 11644},
    '{10000, 0, -32768, -16467,     0},
    '{10000, 0,  24576, -11644, 11644}
`endif
  };

  initial begin
    int seen, chg, rdy;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.z_in      = '0;
`ifdef CORDIC_GAIN_COMP_EN
    ag = 1.0;
`else
    ag = 1.0;
    for (int i = 0; i < N; i++) ag = ag * $sqrt(1.0 + $pow(2.0, -2.0 * i));
`endif

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", int'(bus.in_ready), 1, 0);
    check("rst_out_valid", int'(bus.out_valid), 0, 0);
    check("rst_x_out", int'(bus.x_out), 0, 0);
    check("rst_y_out", int'(bus.y_out), 0, 0);
    check("rst_z_out", int'(bus.z_out), 0, 0);
    check("rst_state", int'(state), int'(S_IDLE), 0);

    // Directed vectors
    for (int v = 0; v < 4; v++) begin
      run_op($sformatf("dir%0d", v), vec[v][0], vec[v][1], vec[v][2], vec[v][3], vec[v][4], TOL);
      check($sformatf("dir%0d_in_ready", v), int'(bus.in_ready), 1, 0);
    end

    // Reset in the middle of an iteration
    send_op(10000, 0, 0);
    for (int k = 0; k < 5; k++) tick();
    check("mid_state_iter", int'(state), int'(S_ITER), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", int'(state), int'(S_IDLE), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1, 0);
    check("mid_rst_x_out", int'(bus.x_out), 0, 0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("mid_rst_no_valid", seen, 0, 0);

    // Output backpressure with a pending operand
    bus.out_ready = 1'b0;
    exp_q.push_back(W'(vec[1][3]));
    exp_q.push_back(W'(vec[1][4]));
    send_op(10000, 0, 8192);
    wait_result();
    check("bp_lat", last_lat, LAT, 0);
    bus.x_in     = W'(10000);
    bus.y_in     = '0;
    bus.z_in     = '0;
    bus.in_valid = 1'b1;
    chg = 0;
    rdy = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.x_out !== rx || bus.y_out !== ry || bus.z_out !== rz) chg++;
      if (bus.in_ready) rdy++;
      if (!bus.out_valid) seen++;
    end
    check("bp_stable", chg, 0, 0);
    check("bp_in_ready", rdy, 0, 0);
    check("bp_valid_held", seen, 0, 0);
    score("bp", TOL);
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", int'(bus.out_valid), 0, 0);
    check("bp_release_ready", int'(bus.in_ready), 1, 0);
    tick();
    bus.in_valid = 1'b0;
    check("bp_accept_state", int'(state), int'(S_ITER), 0);
    check("bp_accept_ready", int'(bus.in_ready), 0, 0);
    exp_q.push_back(W'(vec[0][3]));
    exp_q.push_back(W'(vec[0][4]));
    wait_result();
    check("bp_next_lat", last_lat, LAT, 0);
    score("bp_next", TOL);
    tick();

    // Random sweep against a real-valued model
    for (int k = 0; k < 1000; k++) begin
      int x, y, z;
      real th, ex, ey;
      x  = int'($urandom_range(27800)) - 13900;
      y  = int'($urandom_range(27800)) - 13900;
      z  = int'($urandom_range(65535)) - 32768;
      th = z * PI / 32768.0;
      ex = ag * (x * $cos(th) - y * $sin(th));
      ey = ag * (x * $sin(th) + y * $cos(th));
      run_op("sweep", x, y, z, int'(ex), int'(ey), SWEEP_TOL);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
